// File: rtl/scan_pkg.sv
// Shared constants, command and error codes, FSM states and the scan settings record
// used by scan_cmd_parser.
package scan_pkg;

  localparam logic [7:0] HDR_DEFAULT = 8'hA5;

  localparam logic [7:0] CMD_LOAD  = 8'h01;
  localparam logic [7:0] CMD_START = 8'h02;

  localparam logic [1:0] ERR_CHECKSUM = 2'b00;
  localparam logic [1:0] ERR_BAD_CMD  = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_REJECT   = 2'b11;

  localparam int LOAD_LEN = 17;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    PAYLOAD,
    CHK,
    COMMIT
  } state_t;

  // Field order matches LOAD payload order, so shifting bytes in MSB-first fills it big-endian.
  typedef struct packed {
    logic [15:0] nx_pix;
    logic [15:0] ny_pix;
    logic [31:0] pixel_time;
    logic [15:0] nx_min;
    logic [15:0] nx_max;
    logic [15:0] ny_min;
    logic [15:0] ny_max;
    logic [7:0]  zero_point;
  } scan_cfg_t;

  function automatic logic cfg_ok(input scan_cfg_t c);
    return (c.nx_pix != '0) && (c.ny_pix != '0) &&
           (c.nx_min <= c.nx_max) && (c.ny_min <= c.ny_max);
  endfunction

endpackage

// File: rtl/scan_cmd_parser_if.sv
// Host byte stream into the scan command parser: one byte per rx_valid cycle.
interface scan_cmd_parser_if;
  logic [7:0] rx_data;
  logic       rx_valid;

  modport master (output rx_data, output rx_valid);
  modport slave  (input  rx_data, input  rx_valid);
endinterface

// File: rtl/scan_byte_timer.sv
// Inter-byte watchdog: counts idle cycles while run is high, restarts on kick,
// and flags expired during the TIMEOUT_CYC-th consecutive idle cycle.
module scan_byte_timer #(
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic kick,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] count_q;

  assign expired = run && !kick && (count_q == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (reset || !run || kick) begin
      count_q <= '0;
    end else if (!expired) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/scan_cmd_parser.sv
// Scan command parser: HDR, CMD, payload[, CHK] frames into registered scan parameters.
// Define SCAN_CMD_CHECKSUM_EN to require a trailing XOR checksum byte on every frame.
module scan_cmd_parser
  import scan_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter logic [7:0]  HDR_BYTE    = HDR_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  scan_cmd_parser_if.slave host,
  output logic [15:0]      nx_pix,
  output logic [15:0]      ny_pix,
  output logic [31:0]      pixel_time,
  output logic [15:0]      nx_min,
  output logic [15:0]      nx_max,
  output logic [15:0]      ny_min,
  output logic [15:0]      ny_max,
  output logic [7:0]       zero_point,
  output logic             send_en,
  output logic             cfg_valid,
  output logic             busy,
  output logic             frame_err,
  output logic [1:0]       err_code
);

`ifdef SCAN_CMD_CHECKSUM_EN
  localparam state_t FRAME_END = CHK;
`else
  localparam state_t FRAME_END = COMMIT;
`endif

  state_t    state_q, state_d;
  logic [7:0] cmd_q;
  logic [4:0] idx_q;
  scan_cfg_t shadow_q, cfg_q;
  logic      timer_run, timer_expired;
  logic      take_cmd, take_payload, err_set;
  logic [1:0] err_val;
`ifdef SCAN_CMD_CHECKSUM_EN
  logic [7:0] chk_q;
`endif

  // COMMIT never waits for a byte, so the watchdog only runs while a byte is expected.
  assign timer_run = (state_q != IDLE) && (state_q != COMMIT);
  assign busy      = (state_q != IDLE);

  scan_byte_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .run    (timer_run),
    .kick   (host.rx_valid),
    .expired(timer_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path infers a latch.
    state_d      = state_q;
    take_cmd     = 1'b0;
    take_payload = 1'b0;
    err_set      = 1'b0;
    err_val      = ERR_CHECKSUM;
    unique case (state_q)
      IDLE: begin
        if (host.rx_valid && (host.rx_data == HDR_BYTE)) state_d = CMD;
      end
      CMD: begin
        if (host.rx_valid) begin
          take_cmd = 1'b1;
          if (host.rx_data == CMD_LOAD) begin
            state_d = PAYLOAD;
          end else if (host.rx_data == CMD_START) begin
            state_d = FRAME_END;
          end else begin
            err_set = 1'b1;
            err_val = ERR_BAD_CMD;
            state_d = IDLE;
          end
        end
      end
      PAYLOAD: begin
        if (host.rx_valid) begin
          take_payload = 1'b1;
          if (idx_q == 5'(LOAD_LEN - 1)) state_d = FRAME_END;
        end
      end
`ifdef SCAN_CMD_CHECKSUM_EN
      CHK: begin
        if (host.rx_valid) begin
          if (host.rx_data == chk_q) begin
            state_d = COMMIT;
          end else begin
            err_set = 1'b1;
            err_val = ERR_CHECKSUM;
            state_d = IDLE;
          end
        end
      end
`endif
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (timer_expired) begin
      take_cmd     = 1'b0;
      take_payload = 1'b0;
      err_set      = 1'b1;
      err_val      = ERR_TIMEOUT;
      state_d      = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: shadows are cleared on reset too, so an abandoned frame leaves nothing behind.
      cmd_q     <= '0;
      idx_q     <= '0;
      shadow_q  <= '0;
      cfg_q     <= '0;
      cfg_valid <= 1'b0;
      send_en   <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= '0;
`ifdef SCAN_CMD_CHECKSUM_EN
      chk_q     <= '0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      send_en   <= 1'b0;
      frame_err <= err_set;
      if (err_set) err_code <= err_val;

      if (state_q == IDLE) begin
        idx_q    <= '0;
        shadow_q <= '0;
      end
      if (take_cmd) cmd_q <= host.rx_data;
      if (take_payload) begin
        shadow_q <= {shadow_q[$bits(scan_cfg_t)-9:0], host.rx_data};
        idx_q    <= idx_q + 5'd1;
      end
`ifdef SCAN_CMD_CHECKSUM_EN
      if (state_q == IDLE) chk_q <= '0;
      else if (take_cmd)   chk_q <= host.rx_data;
      else if (take_payload) chk_q <= chk_q ^ host.rx_data;
`endif

      if (state_q == COMMIT) begin
        if (cmd_q == CMD_LOAD) begin
          if (cfg_ok(shadow_q)) begin
            cfg_q     <= shadow_q;
            cfg_valid <= 1'b1;
          end else begin
            frame_err <= 1'b1;
            err_code  <= ERR_REJECT;
          end
        end else if (cfg_valid) begin
          send_en <= 1'b1;
        end else begin
          frame_err <= 1'b1;
          err_code  <= ERR_REJECT;
        end
      end
    end
  end

  assign nx_pix     = cfg_q.nx_pix;
  assign ny_pix     = cfg_q.ny_pix;
  assign pixel_time = cfg_q.pixel_time;
  assign nx_min     = cfg_q.nx_min;
  assign nx_max     = cfg_q.nx_max;
  assign ny_min     = cfg_q.ny_min;
  assign ny_max     = cfg_q.ny_max;
  assign zero_point = cfg_q.zero_point;

endmodule

// File: tb/tb_scan_cmd_parser.sv
// Self-checking bench for scan_cmd_parser: directed vector table, hand-written corner
// sequences (timeout, line noise, reset mid-frame) and randomized frames against a model.
module tb_scan_cmd_parser;

  localparam int         TO  = 16;
  localparam logic [7:0] HDR = 8'hA5;

  typedef struct packed {
    logic [15:0] nx_pix;
    logic [15:0] ny_pix;
    logic [31:0] pixel_time;
    logic [15:0] nx_min;
    logic [15:0] nx_max;
    logic [15:0] ny_min;
    logic [15:0] ny_max;
    logic [7:0]  zero_point;
  } cfg_t;

  typedef struct {
    logic [7:0] cmd;
    cfg_t       cfg;
    bit         bad_chk;
    bit         early;
    cfg_t       exp_out;
    bit         exp_cv;
    logic [1:0] exp_err;
    bit         exp_ferr;
    bit         exp_send;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] nx_pix, ny_pix, nx_min, nx_max, ny_min, ny_max;
  logic [31:0] pixel_time;
  logic [7:0]  zero_point;
  logic        send_en, cfg_valid, busy, frame_err;
  logic [1:0]  err_code;

  scan_cmd_parser_if host_if ();

  scan_cmd_parser #(.TIMEOUT_CYC(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .host      (host_if),
    .nx_pix    (nx_pix),
    .ny_pix    (ny_pix),
    .pixel_time(pixel_time),
    .nx_min    (nx_min),
    .nx_max    (nx_max),
    .ny_min    (ny_min),
    .ny_max    (ny_max),
    .zero_point(zero_point),
    .send_en   (send_en),
    .cfg_valid (cfg_valid),
    .busy      (busy),
    .frame_err (frame_err),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  cfg_t       m_cfg;
  bit         m_cv;
  logic [1:0] m_err;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic cfg_t mk(input logic [31:0] nx, ny, pt, x0, x1, y0, y1, zp);
    cfg_t c;
    c.nx_pix = 16'(nx);  c.ny_pix = 16'(ny);  c.pixel_time = pt;
    c.nx_min = 16'(x0);  c.nx_max = 16'(x1);
    c.ny_min = 16'(y0);  c.ny_max = 16'(y1);
    c.zero_point = 8'(zp);
    return c;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    host_if.rx_data  = b;
    host_if.rx_valid = 1'b1;
    tick();
    host_if.rx_valid = 1'b0;
    host_if.rx_data  = 8'h00;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input cfg_t c, input bit bad_chk, input int gap_max);
    logic [7:0]   q[$];
    logic [135:0] bits;
    logic [7:0]   x;
    bits = c;
    q.push_back(HDR);
    q.push_back(cmd);
    if (cmd == 8'h01)
      for (int i = 0; i < 17; i++) q.push_back(bits[8*(16-i) +: 8]);
`ifdef SCAN_CMD_CHECKSUM_EN
    if (cmd == 8'h01 || cmd == 8'h02) begin
      x = 8'h00;
      for (int i = 1; i < q.size(); i++) x = x ^ q[i];
      if (bad_chk) x = ~x;
      q.push_back(x);
    end
`else
    x = 8'(bad_chk);
`endif
    for (int i = 0; i < q.size(); i++) begin
      send_byte(q[i]);
      if (i != q.size() - 1)
        repeat ($urandom_range(0, gap_max)) tick();
    end
  endtask

  task automatic check_outputs(input string tag, input cfg_t c, input bit cv, input logic [1:0] err,
                               input bit ferr, input bit snd);
    check({tag, " nx/ny_pix"}, 64'({nx_pix, ny_pix}), 64'({c.nx_pix, c.ny_pix}));
    check({tag, " pixel_time"}, 64'(pixel_time), 64'(c.pixel_time));
    check({tag, " x/y range"}, {nx_min, nx_max, ny_min, ny_max}, {c.nx_min, c.nx_max, c.ny_min, c.ny_max});
    check({tag, " zero_point"}, 64'(zero_point), 64'(c.zero_point));
    check({tag, " cfg_valid"}, 64'(cfg_valid), 64'(cv));
    check({tag, " err_code"}, 64'(err_code), 64'(err));
    check({tag, " frame_err"}, 64'(frame_err), 64'(ferr));
    check({tag, " send_en"}, 64'(send_en), 64'(snd));
    check({tag, " busy"}, 64'(busy), 64'd0);
  endtask

  // Model: outcome of one frame from the command rules, updating the model's registers.
  task automatic model_frame(input logic [7:0] cmd, input cfg_t c, input bit bad_chk,
                             output bit early, output bit ferr, output bit snd);
    early = 1'b0; ferr = 1'b0; snd = 1'b0;
    if (cmd != 8'h01 && cmd != 8'h02) begin
      early = 1'b1; ferr = 1'b1; m_err = 2'b01;
    end else if (bad_chk) begin
      early = 1'b1; ferr = 1'b1; m_err = 2'b00;
    end else if (cmd == 8'h01) begin
      if (c.nx_pix == 0 || c.ny_pix == 0 || c.nx_min > c.nx_max || c.ny_min > c.ny_max) begin
        ferr = 1'b1; m_err = 2'b11;
      end else begin
        m_cfg = c; m_cv = 1'b1;
      end
    end else if (m_cv) begin
      snd = 1'b1;
    end else begin
      ferr = 1'b1; m_err = 2'b11;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    cfg_t A, B, C, D, E, F, Z, rc;
    bit   early, ferr, snd, bad;
    logic [7:0] cmd, nb;
    int   r;

    A = mk(256, 128, 1000, 0, 4095, 0, 4095, 0);
    B = mk(256, 128, 1000, 100, 50, 0, 4095, 0);
    C = mk(0, 128, 1000, 0, 4095, 0, 4095, 0);
    D = mk(1, 1, 32'hDEADBEEF, 5, 5, 7, 7, 8'hA5);
    E = mk(2, 2, 7, 0, 1, 0, 1, 9);
    F = mk(640, 480, 50, 10, 600, 20, 400, 3);
    Z = '0;

    vecs.push_back('{8'h02, Z, 1'b0, 1'b0, Z, 1'b0, 2'b11, 1'b1, 1'b0});
    vecs.push_back('{8'h01, A, 1'b0, 1'b0, A, 1'b1, 2'b11, 1'b0, 1'b0});
    vecs.push_back('{8'h02, Z, 1'b0, 1'b0, A, 1'b1, 2'b11, 1'b0, 1'b1});
    vecs.push_back('{8'h01, B, 1'b0, 1'b0, A, 1'b1, 2'b11, 1'b1, 1'b0});
    vecs.push_back('{8'h01, C, 1'b0, 1'b0, A, 1'b1, 2'b11, 1'b1, 1'b0});
    vecs.push_back('{8'h07, Z, 1'b0, 1'b1, A, 1'b1, 2'b01, 1'b1, 1'b0});
    vecs.push_back('{8'h01, D, 1'b0, 1'b0, D, 1'b1, 2'b01, 1'b0, 1'b0});
`ifdef SCAN_CMD_CHECKSUM_EN
    vecs.push_back('{8'h01, E, 1'b1, 1'b1, D, 1'b1, 2'b00, 1'b1, 1'b0});
`else
    vecs.push_back('{8'h01, E, 1'b0, 1'b0, E, 1'b1, 2'b01, 1'b0, 1'b0});
`endif

    reset = 1'b1;
    host_if.rx_valid = 1'b0;
    host_if.rx_data  = 8'h00;
    tick(); tick();
    reset = 1'b0;
    tick();
    check_outputs("reset", Z, 1'b0, 2'b00, 1'b0, 1'b0);

    // Directed vector table.
    for (int i = 0; i < vecs.size(); i++) begin
      send_frame(vecs[i].cmd, vecs[i].cfg, vecs[i].bad_chk, 2);
      if (!vecs[i].early) tick();
      check_outputs($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_cv, vecs[i].exp_err,
                    vecs[i].exp_ferr, vecs[i].exp_send);
      tick();
      check($sformatf("vec%0d pulse end", i), 64'({frame_err, send_en}), 64'd0);
    end

    // Timeout after 5 payload bytes, then a full frame is still accepted.
    send_byte(HDR);
    send_byte(8'h01);
    for (int i = 0; i < 5; i++) send_byte(8'(i + 1));
    repeat (TO - 1) tick();
    check("timeout early frame_err", 64'(frame_err), 64'd0);
    check("timeout busy while waiting", 64'(busy), 64'd1);
    tick();
    check("timeout frame_err", 64'(frame_err), 64'd1);
    check("timeout err_code", 64'(err_code), 64'd2);
    check("timeout busy", 64'(busy), 64'd0);
    tick();
    check("timeout pulse end", 64'(frame_err), 64'd0);
    send_frame(8'h01, F, 1'b0, 2);
    tick();
    check_outputs("after timeout", F, 1'b1, 2'b10, 1'b0, 1'b0);

    // Line noise in IDLE is ignored; unknown command is flagged.
    send_byte(8'h00);
    send_byte(8'hFF);
    check("noise busy", 64'(busy), 64'd0);
    check("noise frame_err", 64'(frame_err), 64'd0);
    send_byte(HDR);
    check("hdr busy", 64'(busy), 64'd1);
    send_byte(8'h07);
    check_outputs("bad cmd", F, 1'b1, 2'b01, 1'b1, 1'b0);

    // Reset in the middle of a LOAD abandons it and clears everything.
    send_byte(HDR);
    send_byte(8'h01);
    for (int i = 0; i < 8; i++) send_byte(8'(i + 1));
    reset = 1'b1;
    tick();
    check_outputs("reset mid-load", Z, 1'b0, 2'b00, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    send_frame(8'h02, Z, 1'b0, 0);
    tick();
    check_outputs("start after reset", Z, 1'b0, 2'b11, 1'b1, 1'b0);

    // Randomized frames against the model.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    m_cfg = '0; m_cv = 1'b0; m_err = 2'b00;
    for (int n = 0; n < 60; n++) begin
      repeat ($urandom_range(0, 2)) begin
        nb = 8'($urandom);
        if (nb == HDR) nb = 8'h00;
        send_byte(nb);
      end
      r = $urandom_range(0, 19);
      if (r < 11)      cmd = 8'h01;
      else if (r < 17) cmd = 8'h02;
      else             cmd = 8'($urandom_range(3, 255));
      rc.nx_pix     = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom);
      rc.ny_pix     = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom);
      rc.pixel_time = $urandom;
      rc.nx_min     = 16'($urandom_range(0, 300));
      rc.nx_max     = 16'($urandom_range(0, 600));
      rc.ny_min     = 16'($urandom_range(0, 300));
      rc.ny_max     = 16'($urandom_range(0, 600));
      rc.zero_point = 8'($urandom);
`ifdef SCAN_CMD_CHECKSUM_EN
      bad = ($urandom_range(0, 7) == 0);
`else
      bad = 1'b0;
`endif
      model_frame(cmd, rc, bad, early, ferr, snd);
      send_frame(cmd, rc, bad, 3);
      if (!early) tick();
      check_outputs($sformatf("rand%0d", n), m_cfg, m_cv, m_err, ferr, snd);
      tick();
      check($sformatf("rand%0d pulse end", n), 64'({frame_err, send_en}), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/scan_cmd_parser.md
SCAN_CMD_PARSER -- requirements
Module: scan_cmd_parser

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 50000, maximum allowed idle cycles between frame bytes.
REQ-002 SHALL have parameter HDR_BYTE, default 8'hA5, frame start marker.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have port rx_data, input, 8 bits, host byte; rx_valid, input, 1 bit, qualifies rx_data for one cycle.
REQ-006 SHALL have output ports nx_pix[15:0], ny_pix[15:0], pixel_time[31:0], nx_min[15:0], nx_max[15:0], ny_min[15:0], ny_max[15:0] and zero_point[7:0], all registered scan parameters.
REQ-007 SHALL have output ports send_en (1-bit start pulse), cfg_valid (1 bit, parameters committed), busy (1 bit, frame in progress), frame_err (1-bit pulse) and err_code[1:0] (last error).

Function
REQ-010 SHALL parse frames HDR, CMD, payload, [CHK]; multi-byte fields are big-endian.
REQ-011 SHALL use FSM states IDLE, CMD, PAYLOAD, CHK and COMMIT; the FSM advances only on rx_valid, except COMMIT, which lasts one cycle.
REQ-012 In IDLE, SHALL discard non-HDR bytes silently; HDR moves to CMD.
REQ-013 SHALL treat CMD 8'h01 (LOAD) as 17 payload bytes in the order nx_pix, ny_pix, pixel_time, nx_min, nx_max, ny_min, ny_max, zero_point.
REQ-014 SHALL treat CMD 8'h02 (START) as having no payload.
REQ-015 SHALL, for any other CMD, pulse frame_err, set err_code=2'b01, and return to IDLE.
REQ-016 SHALL write payload bytes into shadow registers only; outputs SHALL change solely in COMMIT.
REQ-017 SHALL, in COMMIT for LOAD, reject the frame when nx_pix==0, ny_pix==0, nx_min>nx_max or ny_min>ny_max (err_code=2'b11, outputs unchanged).
REQ-018 SHALL otherwise copy all shadows to the outputs atomically in the same cycle and set cfg_valid=1.
REQ-019 SHALL, in COMMIT for START, pulse send_en for exactly one cycle when cfg_valid=1, else raise err_code=2'b11 with no send_en.
REQ-020 SHALL make outputs visible on the cycle after the final frame byte is accepted (latency 1 from that byte's rx_valid edge to COMMIT, outputs registered at COMMIT's end).
REQ-021 SHALL drive busy=1 in every state except IDLE.
REQ-022 SHALL run an inter-byte counter outside IDLE that clears on each rx_valid; on reaching TIMEOUT_CYC it SHALL pulse frame_err, set err_code=2'b10, discard shadows and return to IDLE.
REQ-023 SHALL treat an HDR byte received mid-frame as ordinary data (no resynchronisation).
REQ-024 SHALL hold err_code until the next error; frame_err SHALL be a single-cycle pulse per error.
REQ-025 SHALL keep the existing outputs and cfg_valid on a rejected LOAD.

Reset
REQ-030 SHALL, on reset, put the FSM in IDLE, set all parameter outputs, cfg_valid, send_en, busy, frame_err and err_code to 0, clear shadows and counter; reset mid-frame SHALL abandon the frame without error.

Configuration
REQ-040 SHALL, with SCAN_CMD_CHECKSUM_EN defined, require a CHK byte equal to the XOR of CMD and all payload bytes; on mismatch it SHALL pulse frame_err, set err_code=2'b00, commit nothing, and return to IDLE.
REQ-041 SHALL, without SCAN_CMD_CHECKSUM_EN, omit the CHK state, so the frame ends at the last payload byte (START: after CMD).

Structure
REQ-050 SHALL take HDR default, command codes, error codes, payload length (17) and the FSM state enum from shared package scan_pkg.
REQ-051 SHALL implement the inter-byte timeout counter as sub-module scan_byte_timer (inputs clk, reset, run, kick; output expired).

Verification
REQ-060 LOAD nx_pix=256, ny_pix=128, pixel_time=1000, x 0..4095, y 0..4095, zero_point=0 with correct CHK -> outputs equal those values 1 cycle after CHK, cfg_valid=1, no frame_err.
REQ-061 START after REQ-060 -> send_en high exactly 1 cycle; START immediately after reset -> no send_en, err_code=2'b11.
REQ-062 LOAD with a CHK byte inverted -> frame_err pulse, err_code=2'b00, outputs retain their previous values.
REQ-063 LOAD with nx_min=100, nx_max=50 -> err_code=2'b11, cfg_valid unchanged.
REQ-064 TIMEOUT_CYC=16, stop after 5 payload bytes -> frame_err 16 cycles after the last byte, err_code=2'b10, busy=0; the next full frame is accepted.
REQ-065 Bytes 8'h00, 8'hFF, then HDR, 8'h07 -> first two ignored, then err_code=2'b01; reset asserted mid-LOAD -> all outputs 0 the next cycle.
